// File: rtl/gray_pkg.sv
// Shared types and constants for the RGB565 to grayscale stream block.
// Luma weights are scaled so that white maps to 250.
package gray_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [31:0] K_R = 32'd54;
    localparam logic [31:0] K_G = 32'd183;
    localparam logic [31:0] K_B = 32'd19;

    localparam int SH_R = 5;
    localparam int SH_G = 6;
    localparam int SH_B = 5;

    localparam int PIX_W = 16;
    localparam int R_LO  = 11;
    localparam int R_W   = 5;
    localparam int G_LO  = 5;
    localparam int G_W   = 6;
    localparam int B_LO  = 0;
    localparam int B_W   = 5;

endpackage

// File: rtl/gray_pixel.sv
// Combinational RGB565 to 8-bit gray conversion for one pixel.
// Each weighted term is floored on its own before the sum.
module gray_pixel
    import gray_pkg::*;
(
    input  logic [R_W-1:0] r,
    input  logic [G_W-1:0] g,
    input  logic [B_W-1:0] b,
    output logic [7:0]     y
);

    logic [31:0] t_r;
    logic [31:0] t_g;
    logic [31:0] t_b;

    assign t_r = (32'(r) * K_R) >> SH_R;
    assign t_g = (32'(g) * K_G) >> SH_G;
    assign t_b = (32'(b) * K_B) >> SH_B;

    assign y = 8'(t_r + t_g + t_b);

endmodule

// File: rtl/grayscale_stream_ctrl.sv
// Frame sequencer: two RGB565 pixels in per word, four gray bytes out per word.
// Tracks remaining pixels, packs half words and flushes an odd trailing pair.
module grayscale_stream_ctrl
    import gray_pkg::*;
#(
    parameter int CNT_W = 20
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [CNT_W-1:0] pixel_count,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_last
);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] start_cnt;
    logic [15:0]      packer;
    logic             half_full;
    logic [7:0]       g0;
    logic [7:0]       g1;
    logic             accept;
    logic             out_take;
    logic             out_free;
    logic             last_pair;
    logic             load_pair;
    logic             load_flush;

    gray_pixel u_px0 (
        .r (in_data[R_LO +: R_W]),
        .g (in_data[G_LO +: G_W]),
        .b (in_data[B_LO +: B_W]),
        .y (g0)
    );

    gray_pixel u_px1 (
        .r (in_data[PIX_W + R_LO +: R_W]),
        .g (in_data[PIX_W + G_LO +: G_W]),
        .b (in_data[PIX_W + B_LO +: B_W]),
        .y (g1)
    );

    // Frames are always an even number of pixels.
    assign start_cnt  = pixel_count & ~CNT_W'(1);
    assign accept     = in_valid && in_ready;
    assign out_take   = out_valid && out_ready;
    assign out_free   = !out_valid || out_ready;
    assign last_pair  = (remaining == CNT_W'(2));
    assign load_pair  = accept && half_full;
    assign load_flush = (state == FLUSH) && out_free;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (start_cnt == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (accept && last_pair) begin
                    state_nx = half_full ? DRAIN : FLUSH;
                end
            end
            FLUSH: begin
                if (out_free) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (!out_valid || (out_take && out_last)) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // A full packer with a stalled output word must not accept more input.
    always_comb begin
        busy     = (state != IDLE);
        in_ready = (state == RUN)
                && (remaining != '0)
                && !(half_full && out_valid && !out_ready);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            remaining <= '0;
            packer    <= '0;
            half_full <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= (state == DRAIN) && (state_nx == IDLE);

            if ((state == IDLE) && start) begin
                remaining <= start_cnt;
                half_full <= 1'b0;
            end else if (accept) begin
                remaining <= remaining - CNT_W'(2);
                if (half_full) begin
                    half_full <= 1'b0;
                end else begin
                    packer    <= {g1, g0};
                    half_full <= 1'b1;
                end
            end else if (load_flush) begin
                half_full <= 1'b0;
            end

            if (load_pair) begin
                out_data  <= {g1, g0, packer};
                out_valid <= 1'b1;
                out_last  <= last_pair;
            end else if (load_flush) begin
                out_data  <= {16'h0000, packer};
                out_valid <= 1'b1;
                out_last  <= 1'b1;
            end else if (out_take) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule
